// File: rtl/reg_scan_display.sv
// Scans a 4x4 register file into a shadow buffer and drives a multiplexed
// common-anode 7-segment display. Optional HEX_DIGITS_EN enables A-F glyphs.
module reg_scan_display #(
  parameter int SCAN_DIV = 50000,
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  output logic                      read_enable,
  output logic [ADDR_W-1:0]         read_out_address,
  input  logic [DATA_W-1:0]         read_data,
  output logic [6:0]                seg,
  output logic [(2**ADDR_W)-1:0]    an,
  output logic                      frame_done
);
  localparam int NUM_DIG = 2**ADDR_W;
  localparam int CW      = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]     LAST     = CW'(SCAN_DIV - 1);
  localparam logic [ADDR_W-1:0] LAST_DIG = ADDR_W'(NUM_DIG - 1);

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, CAPTURE, SHOW} state_t;

  state_t                           state, state_n;
  logic [CW-1:0]                    cnt, cnt_n;
  logic [ADDR_W-1:0]                digit, digit_n;
  logic [NUM_DIG-1:0][DATA_W-1:0]   buffer;
  logic [NUM_DIG-1:0]               an_n;

  function automatic logic [6:0] decode(input logic [DATA_W-1:0] v);
    case (v)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
`ifdef HEX_DIGITS_EN
      4'd10:   decode = 7'b0001000;
      4'd11:   decode = 7'b0000011;
      4'd12:   decode = 7'b1000110;
      4'd13:   decode = 7'b0100001;
      4'd14:   decode = 7'b0000110;
      default: decode = 7'b0001110;
`else
      default: decode = 7'b0111111;
`endif
    endcase
  endfunction

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    digit_n = digit;
    if (!en) begin
      state_n = IDLE;
      cnt_n   = '0;
      digit_n = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = ADDR;
          cnt_n   = '0;
          digit_n = '0;
        end
        ADDR: begin
          state_n = WAIT;
          cnt_n   = cnt + CW'(1);
        end
        WAIT: begin
          state_n = CAPTURE;
          cnt_n   = cnt + CW'(1);
        end
        CAPTURE: begin
          state_n = SHOW;
          cnt_n   = cnt + CW'(1);
        end
        SHOW: begin
          if (cnt == LAST) begin
            state_n = ADDR;
            cnt_n   = '0;
            digit_n = digit + ADDR_W'(1);
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
          digit_n = '0;
        end
      endcase
    end
  end

  // Anodes are blanked for the whole fetch window; only SHOW lights a digit.
  for (genvar i = 0; i < NUM_DIG; i++) begin : g_an
    assign an_n[i] = !((state_n == SHOW) && (digit_n == ADDR_W'(i)));
  end

  // Outputs are registered from next-state values so they line up with the
  // state they describe, and seg/an switch on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      cnt              <= '0;
      digit            <= '0;
      buffer           <= '0;
      read_enable      <= 1'b0;
      read_out_address <= '0;
      an               <= '1;
      seg              <= 7'b1111111;
      frame_done       <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      digit <= digit_n;
      if (state_n == CAPTURE) buffer[digit_n] <= read_data;
      read_enable <= (state_n == ADDR) || (state_n == WAIT) || (state_n == CAPTURE);
      if (state_n == IDLE)      read_out_address <= '0;
      else if (state_n == ADDR) read_out_address <= digit_n;
      an         <= an_n;
      seg        <= (state_n == SHOW) ? decode(buffer[digit_n]) : 7'b1111111;
      frame_done <= (state_n == SHOW) && (cnt_n == LAST) && (digit_n == LAST_DIG);
    end
  end
endmodule
